// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA-side VRAM read port:
//   VRAM_AW  - width of the display-side word address
//   MEM_AW   - width of the memory-side word address
//   DATA_W   - width of a pixel/memory word
//   CNT_W    - width of the WAIT-state timeout counter
//   state_t  - read FSM state encoding (IDLE / WAIT / REARM)
//   vram_to_mem_addr() - maps a VRAM word address into the memory word space
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int VRAM_AW = 15;
   localparam int MEM_AW  = 22;
   localparam int DATA_W  = 32;
   localparam int CNT_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_REARM = 2'd2
   } state_t;

   // VRAM lives at a fixed word offset inside the memory; the sum simply
   // wraps at the top of the MEM_AW address space.
   function automatic logic [MEM_AW-1:0] vram_to_mem_addr(
      input logic [MEM_AW-1:0]  base,
      input logic [VRAM_AW-1:0] vaddr
   );
      return base + {{(MEM_AW-VRAM_AW){1'b0}}, vaddr};
   endfunction

endpackage

// File: rtl/vram_vga_port.sv
// ---------------------------------------------------------------------------
// vram_vga_port
// Converts the display's level-sensitive VRAM read request into a single
// memory read transaction and returns the word with a one-cycle strobe.
// A read that the memory never acknowledges is abandoned after TIMEOUT
// WAIT cycles; FILL_WORD is returned instead and a sticky flag is raised.
//
// Parameters
//   VRAM_BASE  memory word address of VRAM word 0
//   TIMEOUT    WAIT cycles before a read is abandoned
//   FILL_WORD  data returned for an abandoned read
//
// Ports
//   vga_clk       in   single clock, all logic on its rising edge
//   reset_n       in   asynchronous active-low reset
//   vram_addr     in   [15] display word address
//   vram_req      in   level read request from the display
//   vram_data     out  [32] returned pixel word (held between strobes)
//   vram_ready    out  one-cycle strobe marking vram_data valid
//   mem_addr      out  [22] memory word address
//   mem_req       out  memory read request
//   mem_ack       in   one-cycle strobe marking mem_rdata valid
//   mem_rdata     in   [32] memory read data
//   timeout_clr   in   synchronous clear of timeout_flag
//   timeout_flag  out  sticky flag, set whenever a read is abandoned
// ---------------------------------------------------------------------------
module vram_vga_port
   import vga_pkg::*;
#(
   parameter logic [MEM_AW-1:0] VRAM_BASE = 22'h000000,
   parameter logic [CNT_W-1:0]  TIMEOUT   = 8'd255,
   parameter logic [DATA_W-1:0] FILL_WORD = 32'h00000000
) (
   input  logic                vga_clk,
   input  logic                reset_n,
   input  logic [VRAM_AW-1:0]  vram_addr,
   input  logic                vram_req,
   output logic [DATA_W-1:0]   vram_data,
   output logic                vram_ready,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic                mem_req,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                timeout_clr,
   output logic                timeout_flag
);

   state_t              r_state;
   state_t              w_state_next;

   logic [MEM_AW-1:0]   r_mem_addr;
   logic [MEM_AW-1:0]   w_mem_addr_next;
   logic                r_mem_req;
   logic                w_mem_req_next;
   logic [DATA_W-1:0]   r_vram_data;
   logic [DATA_W-1:0]   w_vram_data_next;
   logic                r_vram_ready;
   logic                w_vram_ready_next;
   logic                r_timeout_flag;
   logic                w_timeout_flag_next;
   logic [CNT_W-1:0]    r_wait_cnt;
   logic [CNT_W-1:0]    w_wait_cnt_next;

   logic [CNT_W-1:0]    w_wait_cnt_inc;
   logic                w_timeout_hit;

   // The counter holds the number of completed WAIT cycles; the read is
   // abandoned at the edge where that count reaches TIMEOUT, so mem_req is
   // high for exactly TIMEOUT cycles when no ack arrives.
   assign w_wait_cnt_inc = r_wait_cnt + CNT_W'(1);
   assign w_timeout_hit  = (w_wait_cnt_inc == TIMEOUT);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next        = r_state;
      w_mem_addr_next     = r_mem_addr;
      w_mem_req_next      = r_mem_req;
      w_vram_data_next    = r_vram_data;
      w_vram_ready_next   = 1'b0;
      w_wait_cnt_next     = r_wait_cnt;
      // A clear is applied unless a timeout in this same cycle sets it again.
      w_timeout_flag_next = r_timeout_flag & ~timeout_clr;

      case (r_state)
         ST_IDLE: begin
            if (vram_req) begin
               // mem_addr itself is the latched copy of the request address,
               // so the display may change vram_addr while the read is open.
               w_mem_addr_next = vram_to_mem_addr(VRAM_BASE, vram_addr);
               w_mem_req_next  = 1'b1;
               w_wait_cnt_next = '0;
               w_state_next    = ST_WAIT;
            end
         end

         ST_WAIT: begin
            w_wait_cnt_next = w_wait_cnt_inc;
            // The ack is tested first so that an ack on the timeout cycle
            // returns real data and leaves the flag alone.
            if (mem_ack) begin
               w_vram_data_next  = mem_rdata;
               w_vram_ready_next = 1'b1;
               w_mem_req_next    = 1'b0;
               w_state_next      = ST_REARM;
            end else if (w_timeout_hit) begin
               w_vram_data_next    = FILL_WORD;
               w_vram_ready_next   = 1'b1;
               w_mem_req_next      = 1'b0;
               w_timeout_flag_next = 1'b1;
               w_state_next        = ST_REARM;
            end
         end

         ST_REARM: begin
            // The display's request is a level; it must be seen low once
            // before another read may start, otherwise the request that was
            // just served would be issued again.
            if (!vram_req) begin
               w_state_next = ST_IDLE;
            end
         end

         default: begin
            w_mem_req_next = 1'b0;
            w_state_next   = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output and counter registers
   // ------------------------------------------------------------------
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_addr     <= '0;
         r_mem_req      <= 1'b0;
         r_vram_data    <= '0;
         r_vram_ready   <= 1'b0;
         r_timeout_flag <= 1'b0;
         r_wait_cnt     <= '0;
      end else begin
         r_mem_addr     <= w_mem_addr_next;
         r_mem_req      <= w_mem_req_next;
         r_vram_data    <= w_vram_data_next;
         r_vram_ready   <= w_vram_ready_next;
         r_timeout_flag <= w_timeout_flag_next;
         r_wait_cnt     <= w_wait_cnt_next;
      end
   end

   assign mem_addr     = r_mem_addr;
   assign mem_req      = r_mem_req;
   assign vram_data    = r_vram_data;
   assign vram_ready   = r_vram_ready;
   assign timeout_flag = r_timeout_flag;

endmodule
